// File: rtl/ahb2_bus_nm.sv
// N-master, single-slave AHB2 shared bus: hbusreq/hgrant arbitration, address/data phase muxing, parking on last owner.
// Round-robin by default; define AHB2_BUS_FIXED_PRIO_EN for fixed priority (master 0 highest).
module ahb2_bus_nm #(
    parameter int unsigned NUM_MST   = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MST_IDX_W = $clog2(NUM_MST)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_MST-1:0]          m_hbusreq,
    output logic [NUM_MST-1:0]          m_hgrant,
    input  logic [NUM_MST*2-1:0]        m_htrans,
    input  logic [NUM_MST*ADDR_W-1:0]   m_haddr,
    input  logic [NUM_MST-1:0]          m_hwrite,
    input  logic [NUM_MST*3-1:0]        m_hsize,
    input  logic [NUM_MST*3-1:0]        m_hburst,
    input  logic [NUM_MST*DATA_W-1:0]   m_hwdata,
    output logic                        m_hready,
    output logic [1:0]                  m_hresp,
    output logic [DATA_W-1:0]           m_hrdata,
    output logic [MST_IDX_W-1:0]        hmaster,
    output logic [1:0]                  s_htrans,
    output logic [ADDR_W-1:0]           s_haddr,
    output logic                        s_hwrite,
    output logic [2:0]                  s_hsize,
    output logic [2:0]                  s_hburst,
    output logic [DATA_W-1:0]           s_hwdata,
    input  logic                        s_hready,
    input  logic [1:0]                  s_hresp,
    input  logic [DATA_W-1:0]           s_hrdata
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    typedef enum logic {
        IDLE_PARK = 1'b0,
        OWNED     = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [MST_IDX_W-1:0]   data_owner;
    logic [MST_IDX_W-1:0]   hmaster_nxt;
    logic [NUM_MST-1:0]     grant_nxt;
    logic [NUM_MST-1:0]     own_onehot;
    logic [1:0]             own_trans;
    logic                   own_req;
    logic                   others_req;
    logic [MST_IDX_W-1:0]   winner;
    logic                   handover;

    // Owner view used by the handover rule
    assign own_onehot = NUM_MST'(1) << hmaster;
    assign own_trans  = m_htrans[int'(hmaster)*2 +: 2];
    assign own_req    = m_hbusreq[hmaster];
    assign others_req = |(m_hbusreq & ~own_onehot);

`ifdef AHB2_BUS_FIXED_PRIO_EN
    // Lowest-index requester wins; the owner itself competes, so it keeps the bus if it is the lowest
    always_comb begin
        winner = hmaster;
        for (int i = int'(NUM_MST) - 1; i >= 0; i--) begin
            if (m_hbusreq[i]) winner = MST_IDX_W'(i);
        end
    end
`else
    logic [MST_IDX_W-1:0]   rr_ptr;
    int                     scan_idx;

    // First requester after the last grantee, wrapping; the owner is never a candidate
    always_comb begin
        winner   = hmaster;
        scan_idx = 0;
        for (int i = int'(NUM_MST) - 1; i >= 1; i--) begin
            scan_idx = (int'(rr_ptr) + i) % int'(NUM_MST);
            if (m_hbusreq[scan_idx] && (MST_IDX_W'(scan_idx) != hmaster)) winner = MST_IDX_W'(scan_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rr_ptr <= '0;
        else if (handover) rr_ptr <= winner;
    end
`endif

    // Bursts stay intact: the owner holds hbusreq and non-IDLE htrans until its last beat
    assign handover = s_hready && ((own_trans == HTRANS_IDLE) || !own_req) &&
                      others_req && (winner != hmaster);

    // Next-state and next-grant logic
    always_comb begin
        state_nxt   = state;
        hmaster_nxt = hmaster;
        grant_nxt   = m_hgrant;
        case (state)
            IDLE_PARK: if (s_hready && own_req) state_nxt = OWNED;
            OWNED:     if (s_hready && (own_trans == HTRANS_IDLE) && !(|m_hbusreq)) state_nxt = IDLE_PARK;
            default:   state_nxt = IDLE_PARK;
        endcase
        if (handover) begin
            state_nxt   = OWNED;
            hmaster_nxt = winner;
            grant_nxt   = NUM_MST'(1) << winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE_PARK;
            hmaster    <= '0;
            m_hgrant   <= NUM_MST'(1);
            data_owner <= '0;
        end else begin
            state    <= state_nxt;
            hmaster  <= hmaster_nxt;
            m_hgrant <= grant_nxt;
            if (s_hready) data_owner <= hmaster;
        end
    end

    // Address phase follows the address owner, write data follows the data owner
    assign s_htrans = rst_n ? m_htrans[int'(hmaster)*2 +: 2] : HTRANS_IDLE;
    assign s_haddr  = m_haddr[int'(hmaster)*int'(ADDR_W) +: ADDR_W];
    assign s_hwrite = m_hwrite[hmaster];
    assign s_hsize  = m_hsize[int'(hmaster)*3 +: 3];
    assign s_hburst = m_hburst[int'(hmaster)*3 +: 3];
    assign s_hwdata = m_hwdata[int'(data_owner)*int'(DATA_W) +: DATA_W];

    assign m_hready = s_hready;
    assign m_hresp  = s_hresp;
    assign m_hrdata = s_hrdata;

endmodule

// File: tb/tb_ahb2_bus_nm.sv
// Self-checking bench for ahb2_bus_nm (round-robin build): scoreboard of slave-side beats plus per-scenario checks.
module tb_ahb2_bus_nm;

    localparam int unsigned NM = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NM-1:0]     req;
    logic [1:0]        tr [NM];
    logic [AW-1:0]     ad [NM];
    logic [NM-1:0]     wr;
    logic [2:0]        sz [NM];
    logic [2:0]        bu [NM];
    logic [DW-1:0]     wd [NM];

    logic [NM-1:0]     m_hbusreq, m_hgrant, m_hwrite;
    logic [NM*2-1:0]   m_htrans;
    logic [NM*AW-1:0]  m_haddr;
    logic [NM*3-1:0]   m_hsize, m_hburst;
    logic [NM*DW-1:0]  m_hwdata;
    logic              m_hready;
    logic [1:0]        m_hresp;
    logic [DW-1:0]     m_hrdata;
    logic [IW-1:0]     hmaster;
    logic [1:0]        s_htrans;
    logic [AW-1:0]     s_haddr;
    logic              s_hwrite;
    logic [2:0]        s_hsize, s_hburst;
    logic [DW-1:0]     s_hwdata;
    logic              s_hready;
    logic [1:0]        s_hresp;
    logic [DW-1:0]     s_hrdata;

    always_comb begin
        m_hbusreq = req;
        m_hwrite  = wr;
        m_htrans  = '0;
        m_haddr   = '0;
        m_hsize   = '0;
        m_hburst  = '0;
        m_hwdata  = '0;
        for (int i = 0; i < int'(NM); i++) begin
            m_htrans[2*i +: 2]  = tr[i];
            m_haddr[AW*i +: AW] = ad[i];
            m_hsize[3*i +: 3]   = sz[i];
            m_hburst[3*i +: 3]  = bu[i];
            m_hwdata[DW*i +: DW] = wd[i];
        end
    end

    ahb2_bus_nm #(.NUM_MST(NM), .ADDR_W(AW), .DATA_W(DW), .MST_IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_hbusreq(m_hbusreq), .m_hgrant(m_hgrant), .m_htrans(m_htrans), .m_haddr(m_haddr),
        .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
        .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata), .hmaster(hmaster),
        .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hresp(s_hresp),
        .s_hrdata(s_hrdata)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t sb [$];
    beat_t dp_exp;
    logic  dp_vld = 1'b0;

    // Slave-side monitor: pops an expected beat per accepted address phase, checks write data on completion
    always @(negedge clk) begin
        if (!rst_n) begin
            dp_vld = 1'b0;
        end else if (s_hready) begin
            if (dp_vld && dp_exp.wr) begin
                n_tests++;
                if (s_hwdata !== dp_exp.data) begin
                    n_fail++;
                    $display("FAIL sb_wdata addr=%h got %h exp %h", dp_exp.addr, s_hwdata, dp_exp.data);
                end
            end
            dp_vld = 1'b0;
            if (s_htrans[1]) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected addr got %h exp none", s_haddr);
                end else begin
                    dp_exp = sb.pop_front();
                    dp_vld = 1'b1;
                    if (s_haddr !== dp_exp.addr || s_hwrite !== dp_exp.wr) begin
                        n_fail++;
                        $display("FAIL sb_addr got %h/%b exp %h/%b", s_haddr, s_hwrite, dp_exp.addr, dp_exp.wr);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_all();
        req = '0;
        wr  = '0;
        for (int i = 0; i < int'(NM); i++) begin
            tr[i] = 2'b00; ad[i] = '0; sz[i] = 3'b010; bu[i] = 3'b000; wd[i] = '0;
        end
        s_hready = 1'b1;
        s_hresp  = 2'b00;
        s_hrdata = '0;
    endtask

    task automatic addr_beat(input int m, input logic [1:0] t, input logic [AW-1:0] a,
                             input logic w, input logic [2:0] b, input logic [DW-1:0] d);
        tr[m] = t; ad[m] = a; wr[m] = w; sz[m] = 3'b010; bu[m] = b;
        if (t[1]) sb.push_back(beat_t'{addr: a, wr: w, data: d});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        req = 4'b1111;
        tr[0] = 2'b10;
        ad[0] = 32'hFFFF_0000;
        repeat (3) @(posedge clk);
        smp();
        n_tests++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL rst_grant got %b exp 0001", m_hgrant); end
        n_tests++; if (hmaster !== 2'd0) begin n_fail++; $display("FAIL rst_hmaster got %0d exp 0", hmaster); end
        n_tests++; if (s_htrans !== 2'b00) begin n_fail++; $display("FAIL rst_htrans got %b exp 00", s_htrans); end
        cyc();
        idle_all();
        rst_n = 1'b1;
    endtask

    task automatic test_parking();
        smp();
        n_tests++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL park_idle got %b exp 0001", m_hgrant); end
        cyc(); req[0] = 1'b1; smp();
        n_tests++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL park_own_req got %b exp 0001", m_hgrant); end
        cyc(); req[0] = 1'b0; smp();
        cyc(); smp();
        n_tests++; if (m_hgrant !== 4'b0001 || hmaster !== 2'd0) begin
            n_fail++; $display("FAIL park_drop got %b/%0d exp 0001/0", m_hgrant, hmaster); end
    endtask

    task automatic test_single_master();
        cyc(); req[1] = 1'b1; smp();
        n_tests++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL sm_latency got %b exp 0001", m_hgrant); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            addr_beat(1, (k == 0) ? 2'b10 : 2'b11, 32'h0002_0000 + 32'(4*k), 1'b1, 3'b011, 32'hA0 + 32'(k));
            if (k > 0) wd[1] = 32'hA0 + 32'(k - 1);
            if (k == 2) req[2] = 1'b1;
            wd[2] = 32'h2222_2222;
            smp();
            n_tests++; if (m_hgrant !== 4'b0010 || hmaster !== 2'd1) begin
                n_fail++; $display("FAIL sm_burst_grant beat=%0d got %b/%0d exp 0010/1", k, m_hgrant, hmaster); end
        end
        cyc(); tr[1] = 2'b00; req[1] = 1'b0; wd[1] = 32'hA3; smp();
        n_tests++; if (m_hgrant !== 4'b0010) begin n_fail++; $display("FAIL sm_last_data got %b exp 0010", m_hgrant); end
        cyc(); smp();
        n_tests++; if (m_hgrant !== 4'b0100 || hmaster !== 2'd2) begin
            n_fail++; $display("FAIL sm_handover got %b/%0d exp 0100/2", m_hgrant, hmaster); end
    endtask

    task automatic test_async_reset();
        cyc(); addr_beat(2, 2'b10, 32'h0004_0000, 1'b1, 3'b011, 32'hB0); smp();
        cyc(); addr_beat(2, 2'b11, 32'h0004_0004, 1'b1, 3'b011, 32'hB1); wd[2] = 32'hB0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL arst_grant got %b exp 0001", m_hgrant); end
        n_tests++; if (hmaster !== 2'd0) begin n_fail++; $display("FAIL arst_hmaster got %0d exp 0", hmaster); end
        n_tests++; if (s_htrans !== 2'b00) begin n_fail++; $display("FAIL arst_htrans got %b exp 00", s_htrans); end
        sb.delete();
        idle_all();
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int exp_q [$];
        int owner;
        logic [NM-1:0] exp_g;
        owner = 0;
        exp_q.push_back(owner);
        for (int k = 0; k < 4; k++) begin
            owner = (owner + 1) % int'(NM);
            exp_q.push_back(owner);
        end
        cyc(); req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = exp_q.pop_front();
            exp_g = NM'(1) << e;
            addr_beat(e, 2'b10, 32'h0000_1000 + 32'(16*k), 1'b0, 3'b000, '0);
            smp();
            n_tests++; if (hmaster !== IW'(e) || m_hgrant !== exp_g) begin
                n_fail++; $display("FAIL rr_order step=%0d got %0d/%b exp %0d/%b", k, hmaster, m_hgrant, e, exp_g); end
            cyc();
            tr[e] = 2'b00;
            if (k == 4) req = '0;
            smp();
            cyc();
        end
        smp();
        n_tests++; if (hmaster !== 2'd0) begin n_fail++; $display("FAIL rr_park got %0d exp 0", hmaster); end
    endtask

    task automatic test_wait_states();
        cyc(); req[2] = 1'b1; smp();
        cyc(); addr_beat(2, 2'b10, 32'h0000_5000, 1'b1, 3'b000, 32'hDEAD_BEEF);
        wd[3] = 32'h3333_3333; wd[0] = 32'h0000_0BAD; smp();
        n_tests++; if (hmaster !== 2'd2) begin n_fail++; $display("FAIL ws_owner got %0d exp 2", hmaster); end
        cyc(); tr[2] = 2'b00; req[2] = 1'b0; req[3] = 1'b1; wd[2] = 32'hDEAD_BEEF; s_hready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            if (w > 0) cyc();
            smp();
            n_tests++; if (m_hgrant !== 4'b0100 || hmaster !== 2'd2) begin
                n_fail++; $display("FAIL ws_freeze w=%0d got %b/%0d exp 0100/2", w, m_hgrant, hmaster); end
            n_tests++; if (s_hwdata !== 32'hDEAD_BEEF) begin
                n_fail++; $display("FAIL ws_wdata w=%0d got %h exp deadbeef", w, s_hwdata); end
            n_tests++; if (m_hready !== 1'b0) begin n_fail++; $display("FAIL ws_hready got %b exp 0", m_hready); end
        end
        cyc(); s_hready = 1'b1; smp();
        n_tests++; if (m_hgrant !== 4'b0100) begin n_fail++; $display("FAIL ws_release got %b exp 0100", m_hgrant); end
        cyc(); smp();
        n_tests++; if (m_hgrant !== 4'b1000 || hmaster !== 2'd3) begin
            n_fail++; $display("FAIL ws_handover got %b/%0d exp 1000/3", m_hgrant, hmaster); end
    endtask

    task automatic test_overlap();
        cyc(); req[3] = 1'b0; req[0] = 1'b1; smp();
        cyc(); addr_beat(0, 2'b10, 32'h0000_6000, 1'b1, 3'b000, 32'h1111);
        req[0] = 1'b0; req[3] = 1'b1; wd[3] = 32'h3333_3333; smp();
        n_tests++; if (hmaster !== 2'd0) begin n_fail++; $display("FAIL ov_owner got %0d exp 0", hmaster); end
        cyc(); tr[0] = 2'b00; wd[0] = 32'h1111;
        addr_beat(3, 2'b10, 32'h0003_0000, 1'b0, 3'b000, '0); smp();
        n_tests++; if (hmaster !== 2'd3) begin n_fail++; $display("FAIL ov_hmaster got %0d exp 3", hmaster); end
        n_tests++; if (s_hwdata !== 32'h1111) begin n_fail++; $display("FAIL ov_wdata got %h exp 00001111", s_hwdata); end
        n_tests++; if (s_haddr !== 32'h0003_0000) begin n_fail++; $display("FAIL ov_haddr got %h exp 00030000", s_haddr); end
        cyc(); tr[3] = 2'b00; req[3] = 1'b0; smp();
    endtask

    task automatic test_error();
        cyc(); req[1] = 1'b1; smp();
        cyc(); addr_beat(1, 2'b10, 32'h0000_7000, 1'b0, 3'b000, '0); smp();
        n_tests++; if (hmaster !== 2'd1) begin n_fail++; $display("FAIL err_owner got %0d exp 1", hmaster); end
        cyc(); tr[1] = 2'b00; req[1] = 1'b0; req[2] = 1'b1; s_hready = 1'b0; s_hresp = 2'b01; smp();
        n_tests++; if (m_hresp !== 2'b01 || m_hready !== 1'b0) begin
            n_fail++; $display("FAIL err_cycle1 got %b/%b exp 01/0", m_hresp, m_hready); end
        n_tests++; if (m_hgrant !== 4'b0010) begin n_fail++; $display("FAIL err_freeze got %b exp 0010", m_hgrant); end
        cyc(); s_hready = 1'b1; s_hrdata = 32'hCAFE_F00D; smp();
        n_tests++; if (m_hresp !== 2'b01 || m_hready !== 1'b1) begin
            n_fail++; $display("FAIL err_cycle2 got %b/%b exp 01/1", m_hresp, m_hready); end
        n_tests++; if (m_hrdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL err_hrdata got %h exp cafef00d", m_hrdata); end
        n_tests++; if (m_hgrant !== 4'b0010) begin n_fail++; $display("FAIL err_hold got %b exp 0010", m_hgrant); end
        cyc(); s_hresp = 2'b00; smp();
        n_tests++; if (m_hgrant !== 4'b0100 || hmaster !== 2'd2) begin
            n_fail++; $display("FAIL err_next_grant got %b/%0d exp 0100/2", m_hgrant, hmaster); end
        cyc(); idle_all(); smp();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        test_reset();
        test_parking();
        test_single_master();
        test_async_reset();
        test_round_robin();
        test_wait_states();
        test_overlap();
        test_error();
        repeat (2) cyc();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover got %0d exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb2_bus_nm.md
Name: ahb2_bus_nm

Overview:
Parametrised N-master, single-slave AHB2 shared-bus interconnect. It replaces the fixed two-master bus between the compression/decompression engines and AHB2 memory.
- Arbitrates with hbusreq/hgrant and muxes address and data phases.
- Parks the bus on the last owner.
- Round-robin by default; fixed priority as a build option.

Parameters:
NUM_MST, 4, number of masters (2..8)
ADDR_W, 32, haddr width
DATA_W, 32, hwdata/hrdata width
MST_IDX_W, $clog2(NUM_MST), master index width

Ports:
clk  in  1  bus clock
rst_n  in  1  asynchronous active-low reset
m_hbusreq  in  NUM_MST  per-master bus request
m_hgrant  out  NUM_MST  one-hot grant
m_htrans  in  NUM_MST*2  per-master htrans, master i at [2i+1:2i]
m_haddr  in  NUM_MST*ADDR_W  per-master haddr
m_hwrite  in  NUM_MST  per-master hwrite
m_hsize  in  NUM_MST*3  per-master hsize
m_hburst  in  NUM_MST*3  per-master hburst
m_hwdata  in  NUM_MST*DATA_W  per-master write data
m_hready  out  1  broadcast hready to all masters
m_hresp  out  2  broadcast hresp
m_hrdata  out  DATA_W  broadcast read data
hmaster  out  MST_IDX_W  current address-phase owner
s_htrans  out  2  slave htrans
s_haddr  out  ADDR_W  slave haddr
s_hwrite  out  1  slave hwrite
s_hsize  out  3  slave hsize
s_hburst  out  3  slave hburst
s_hwdata  out  DATA_W  slave write data
s_hready  in  1  slave hready
s_hresp  in  2  slave hresp
s_hrdata  in  DATA_W  slave read data

Behaviour:
- Reset (async, rst_n=0):
  - m_hgrant=1 (master 0 parked); hmaster=0; data_owner=0.
  - s_htrans=IDLE (forced while rst_n=0); rr pointer=0.
  - Ongoing transfers abandoned, no completion reported.
- Address phase: s_haddr/s_htrans/s_hwrite/s_hsize/s_hburst are combinational muxes of master[hmaster].
- Data phase: data_owner <= hmaster on any clk with s_hready=1. s_hwdata = m_hwdata[data_owner].
- Response path: m_hready=s_hready, m_hresp=s_hresp, m_hrdata=s_hrdata, all pass-through, zero latency.
- Handover point (handover) = s_hready=1 AND (owner htrans==IDLE OR owner hbusreq==0) AND any other master's hbusreq=1.
- Owner holds hbusreq for a whole burst, so bursts (NONSEQ+SEQ/BUSY) are never split.
- Next owner on handover: first requester scanning from hmaster+1 upward with wrap-around; the owner is excluded.
- On handover: m_hgrant and hmaster update at the next clk edge (1-cycle arbitration latency). The new owner drives its first NONSEQ in that cycle.
- The outgoing owner's final data phase completes under data_owner. Address owner and data owner may differ for one transfer.
- No requests: grant stays with current owner (parking), no toggling.
- Owner drops hbusreq while others also idle: grant held.
- Simultaneous requests: exactly one grant; one-hot is an invariant.
- hgrant changes only on s_hready=1 cycles. A slave wait state (s_hready=0) freezes grant, hmaster and data_owner.
- ERROR response: two-cycle hresp=ERROR passed through unchanged. Arbitration is allowed on the second cycle (s_hready=1) like any other.
- State: FSM IDLE_PARK / OWNED. OWNED->IDLE_PARK when owner htrans==IDLE and no requests. Either state -> handover per rule above. State is internal and reflected only via hgrant/hmaster.

Optional Feature:
AHB2_BUS_FIXED_PRIO_EN
- Defined: next owner is the lowest-index requester, master 0 highest priority. Handover point unchanged. The current owner loses the bus at the next handover point if a lower-index master requests.
- Undefined: round-robin as described; rr pointer logic compiled out when defined.

Test Plan:
- Reset: rst_n low 3 cycles -> m_hgrant=4'b0001, hmaster=0, s_htrans=IDLE. Assert rst_n low mid-burst -> same values immediately, asynchronously.
- Single master: m1 requests, issues INCR4 writes at 0x0002_0000, data 0xA0..0xA3 -> grant 4'b0010 one cycle after a handover point. Slave sees 4 beats in order; burst not split even though m2 requests at beat 2.
- Round-robin: all 4 masters hold hbusreq, each does single NONSEQ then IDLE -> grant order 0,1,2,3,0. Fixed-priority build gives 0,0,0 while m0 requests.
- Wait states: s_hready low 3 cycles during m2 data phase -> hgrant/hmaster/data_owner frozen. s_hwdata stays m2's data (0xDEAD_BEEF).
- Handover overlap: m0 last write data 0x1111 with m3 NONSEQ read of 0x0003_0000 in the same cycle -> s_hwdata=0x1111 and s_haddr=0x0003_0000 simultaneously.
- Error: slave returns 2-cycle ERROR to m1 -> m_hresp=ERROR both cycles, m_hready 0 then 1. Pending m2 request granted the following cycle.
